// File: rtl/pc_unit_if.sv
// Fetch-stage control/bus bundle between the PC stage and its driver.
// The driver owns control and operands; the PC stage owns PC and RAS status.
interface pc_unit_if #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic             stall;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic             call;
    logic             ret;
    logic [XLEN-1:0]  immd;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic             misalign;
    logic [XLEN-1:0]  ras_top;
    logic             ras_valid;
    logic [CNT_W-1:0] ras_count;

    modport master (
        output stall, branch, jal, jalr, call, ret, immd, rs1_val,
        input  pc, pc_plus4, misalign, ras_top, ras_valid, ras_count
    );

    modport slave (
        input  stall, branch, jal, jalr, call, ret, immd, rs1_val,
        output pc, pc_plus4, misalign, ras_top, ras_valid, ras_count
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC selection, misaligned-target trap redirect
// and a circular return-address stack for call/return prediction.
module pc_unit #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned IMM_SHIFT    = 1,
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] TRAP_VECTOR  = 64'h100,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);
    localparam int unsigned   PTR_W  = $clog2(RAS_DEPTH);
    localparam int unsigned   CNT_W  = PTR_W + 1;
    localparam logic [XLEN-1:0] RST_PC  = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VECTOR);

    logic [XLEN-1:0]  r_pc;
    logic             r_misalign;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_jalr_tgt;
    logic [XLEN-1:0]  w_rel_tgt;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_redirect;
    logic             w_misalign;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_ras_empty;
    logic             w_ras_full;
    logic             w_push;
    logic             w_replace;
    logic             w_pop;

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_jalr_tgt = (bus.rs1_val + bus.immd) & ~XLEN'(1);
    assign w_rel_tgt  = r_pc + (bus.immd << IMM_SHIFT);

    // jalr outranks branch/jal; everything else falls through sequentially
    always_comb begin
        w_target = w_pc_plus4;
        if (bus.jalr) begin
            w_target = w_jalr_tgt;
        end else if (bus.branch || bus.jal) begin
            w_target = w_rel_tgt;
        end
    end

    assign w_redirect = bus.jalr || bus.branch || bus.jal;
    assign w_misalign = w_redirect && (w_target[1:0] != 2'b00);
    assign w_next_pc  = w_misalign ? TRAP_PC : w_target;

    assign w_top_idx   = r_wp - PTR_W'(1);
    assign w_ras_empty = (r_count == '0);
    assign w_ras_full  = (r_count == CNT_W'(RAS_DEPTH));

    // call+ret replaces the top entry unless the stack is empty, where it pushes
    assign w_push    = bus.call && (!bus.ret || w_ras_empty);
    assign w_replace = bus.call && bus.ret && !w_ras_empty;
    assign w_pop     = bus.ret && !bus.call && !w_ras_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RST_PC;
            r_misalign <= 1'b0;
            r_wp       <= '0;
            r_count    <= '0;
            // Entries are cleared so ras_top is never X downstream
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (!bus.stall) begin
            r_pc       <= w_next_pc;
            r_misalign <= w_misalign;
            if (w_push) begin
                r_ras[r_wp] <= w_pc_plus4;
                r_wp        <= r_wp + PTR_W'(1);
                if (!w_ras_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_replace) begin
                r_ras[w_top_idx] <= w_pc_plus4;
            end else if (w_pop) begin
                r_wp    <= w_top_idx;
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign bus.pc        = r_pc;
    assign bus.pc_plus4  = w_pc_plus4;
    assign bus.misalign  = r_misalign;
    assign bus.ras_top   = r_ras[w_top_idx];
    assign bus.ras_valid = !w_ras_empty;
    assign bus.ras_count = r_count;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: hand-computed vector table, then random stimulus
// compared against a queue-based reference model.
module tb_pc_unit;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic rst, stl, br, jl, jr, cl, rt;
        logic [63:0] imm, rs1;
    } in_t;

    typedef struct {
        in_t         in;
        logic [63:0] pc;
        logic        mis;
        int          cnt;
        logic [63:0] top;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    pc_unit_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

    pc_unit #(
        .XLEN(XLEN), .IMM_SHIFT(1), .RESET_VECTOR(64'h0),
        .TRAP_VECTOR(64'h100), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: PC, trap flag and RAS as a queue (newest at back)
    logic [63:0] m_pc;
    logic        m_mis;
    logic [63:0] m_ras[$];

    function automatic void model_step(input in_t x);
        logic [63:0] p4;
        logic [63:0] tgt;
        logic        red;
        p4 = m_pc + 64'd4;
        if (x.rst) begin
            m_pc  = 64'h0;
            m_mis = 1'b0;
            m_ras.delete();
        end else if (!x.stl) begin
            if (x.jr)              tgt = (x.rs1 + x.imm) & ~64'd1;
            else if (x.br || x.jl) tgt = m_pc + x.imm * 64'd2;
            else                   tgt = p4;
            red = x.jr || x.br || x.jl;
            if (x.cl && x.rt) begin
                if (m_ras.size() == 0) m_ras.push_back(p4);
                else                   m_ras[m_ras.size()-1] = p4;
            end else if (x.cl) begin
                m_ras.push_back(p4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (x.rt && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
            if (red && tgt[1:0] != 2'b00) begin
                m_pc  = 64'h100;
                m_mis = 1'b1;
            end else begin
                m_pc  = tgt;
                m_mis = 1'b0;
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] epc, input logic emis,
                             input int ecnt, input logic [63:0] etop);
        check($sformatf("%s/pc", tag), bus.pc, epc);
        check($sformatf("%s/pc_plus4", tag), bus.pc_plus4, epc + 64'd4);
        check($sformatf("%s/misalign", tag), 64'(bus.misalign), 64'(emis));
        check($sformatf("%s/ras_count", tag), 64'(bus.ras_count), 64'(ecnt));
        check($sformatf("%s/ras_valid", tag), 64'(bus.ras_valid), 64'(ecnt != 0));
        if (ecnt > 0) check($sformatf("%s/ras_top", tag), bus.ras_top, etop);
    endtask

    // Drive one cycle of inputs, advance the model alongside the DUT
    task automatic apply(input in_t x);
        reset       = x.rst;
        bus.stall   = x.stl;
        bus.branch  = x.br;
        bus.jal     = x.jl;
        bus.jalr    = x.jr;
        bus.call    = x.cl;
        bus.ret     = x.rt;
        bus.immd    = x.imm;
        bus.rs1_val = x.rs1;
        @(posedge clk);
        #1;
        model_step(x);
    endtask

    function automatic vec_t mkv(input bit rst, stl, br, jl, jr, cl, rt,
                                 input logic [63:0] imm, rs1, pc,
                                 input bit mis, input int cnt, input logic [63:0] top);
        vec_t v;
        v.in  = '{rst: rst, stl: stl, br: br, jl: jl, jr: jr, cl: cl, rt: rt, imm: imm, rs1: rs1};
        v.pc  = pc;
        v.mis = mis;
        v.cnt = cnt;
        v.top = top;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_pc    = 64'h0;
        m_mis   = 1'b0;
        reset = 1'b1;
        bus.stall = 0; bus.branch = 0; bus.jal = 0; bus.jalr = 0;
        bus.call = 0; bus.ret = 0; bus.immd = '0; bus.rs1_val = '0;

        //            rst stl br jl jr cl rt  immd            rs1               pc                mis cnt top
        tbl.push_back(mkv(1,0,0,0,0,0,0, 64'h0,          64'h0,          64'h0,          0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 64'h0,          64'h0,          64'h4,          0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 64'h0,          64'h0,          64'h8,          0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 64'h0,          64'h0,          64'hc,          0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,1,0,0, 64'h0,          64'h40,         64'h40,         0, 0, 64'h0));
        tbl.push_back(mkv(0,0,1,0,0,0,0, 64'h10,         64'h0,          64'h60,         0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,1,0,0, 64'h0,          64'h40,         64'h40,         0, 0, 64'h0));
        tbl.push_back(mkv(0,0,1,0,1,0,0, 64'h0,          64'h201,        64'h200,        0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,1,0,0, 64'h0,          64'h40,         64'h40,         0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,1,0,0,0, 64'h1,          64'h0,          64'h100,        1, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 64'h0,          64'h0,          64'h104,        0, 0, 64'h0));
        tbl.push_back(mkv(0,1,1,0,0,1,0, 64'h10,         64'h0,          64'h104,        0, 0, 64'h0));
        tbl.push_back(mkv(0,1,1,0,0,1,0, 64'h10,         64'h0,          64'h104,        0, 0, 64'h0));
        tbl.push_back(mkv(0,1,1,0,0,1,0, 64'h10,         64'h0,          64'h104,        0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 64'h0,          64'h0,          64'h108,        0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,1,0,0,0, 64'h1,          64'h0,          64'h100,        1, 0, 64'h0));
        tbl.push_back(mkv(0,1,0,0,0,0,0, 64'h0,          64'h0,          64'h100,        1, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 64'h0,          64'h0,          64'h104,        0, 0, 64'h0));
        tbl.push_back(mkv(1,0,0,0,0,0,0, 64'h0,          64'h0,          64'h0,          0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,1,0,1,0, 64'h8,          64'h0,          64'h10,         0, 1, 64'h4));
        tbl.push_back(mkv(0,0,0,1,0,1,0, 64'h8,          64'h0,          64'h20,         0, 2, 64'h14));
        tbl.push_back(mkv(0,0,0,1,0,1,0, 64'h8,          64'h0,          64'h30,         0, 3, 64'h24));
        tbl.push_back(mkv(0,0,0,1,0,1,0, 64'h8,          64'h0,          64'h40,         0, 4, 64'h34));
        tbl.push_back(mkv(0,0,0,1,0,1,0, 64'h8,          64'h0,          64'h50,         0, 4, 64'h44));
        tbl.push_back(mkv(0,0,0,0,0,0,1, 64'h0,          64'h0,          64'h54,         0, 3, 64'h34));
        tbl.push_back(mkv(0,0,0,0,0,0,1, 64'h0,          64'h0,          64'h58,         0, 2, 64'h24));
        tbl.push_back(mkv(0,0,0,0,0,0,1, 64'h0,          64'h0,          64'h5c,         0, 1, 64'h14));
        tbl.push_back(mkv(0,0,0,0,0,0,1, 64'h0,          64'h0,          64'h60,         0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,0,0,1, 64'h0,          64'h0,          64'h64,         0, 0, 64'h0));
        tbl.push_back(mkv(1,0,0,0,0,0,0, 64'h0,          64'h0,          64'h0,          0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,1,0,1,0, 64'h8,          64'h0,          64'h10,         0, 1, 64'h4));
        tbl.push_back(mkv(0,0,0,1,0,1,0, 64'h8,          64'h0,          64'h20,         0, 2, 64'h14));
        tbl.push_back(mkv(0,0,0,0,1,0,0, 64'h0,          64'h80,         64'h80,         0, 2, 64'h14));
        tbl.push_back(mkv(0,0,0,0,0,1,1, 64'h0,          64'h0,          64'h84,         0, 2, 64'h84));
        tbl.push_back(mkv(0,0,0,0,0,0,1, 64'h0,          64'h0,          64'h88,         0, 1, 64'h4));
        tbl.push_back(mkv(0,0,0,0,0,1,1, 64'h0,          64'h0,          64'h8c,         0, 1, 64'h8c));
        tbl.push_back(mkv(1,0,1,0,1,1,0, 64'h10,         64'h7,          64'h0,          0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,0,0,1,1, 64'h0,          64'h0,          64'h4,          0, 1, 64'h4));
        tbl.push_back(mkv(0,0,0,0,0,0,1, 64'h0,          64'h0,          64'h8,          0, 0, 64'h0));
        tbl.push_back(mkv(0,0,0,1,0,1,0, 64'h1,          64'h0,          64'h100,        1, 1, 64'hc));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 64'h0,          64'h0,          64'h104,        0, 1, 64'hc));
        tbl.push_back(mkv(0,0,0,0,1,0,0, 64'h0,  64'hffff_ffff_ffff_fffc, 64'hffff_ffff_ffff_fffc, 0, 1, 64'hc));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 64'h0,          64'h0,          64'h0,          0, 1, 64'hc));
        tbl.push_back(mkv(0,0,0,0,1,0,0, 64'h1,          64'h12,         64'h100,        1, 1, 64'hc));
        tbl.push_back(mkv(0,0,1,0,0,0,0, 64'hffff_ffff_ffff_fff8, 64'h0, 64'hf0,         0, 1, 64'hc));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].in);
            check_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].mis, tbl[i].cnt, tbl[i].top);
        end

        // Randomised phase against the reference model
        apply('{rst: 1, stl: 0, br: 0, jl: 0, jr: 0, cl: 0, rt: 0, imm: 64'h0, rs1: 64'h0});
        for (int n = 0; n < 3000; n++) begin
            in_t x;
            int  s;
            s = int'($urandom_range(0, 511)) - 256;
            if ($urandom_range(0, 3) != 0) s = s & ~1;
            x.rst = ($urandom_range(0, 99) == 0);
            x.stl = ($urandom_range(0, 7) == 0);
            x.br  = ($urandom_range(0, 3) == 0);
            x.jl  = ($urandom_range(0, 7) == 0);
            x.jr  = ($urandom_range(0, 7) == 0);
            x.cl  = ($urandom_range(0, 3) == 0);
            x.rt  = ($urandom_range(0, 3) == 0);
            x.imm = 64'(s);
            if ($urandom_range(0, 15) == 0) x.rs1 = {$urandom, $urandom};
            else                            x.rs1 = 64'($urandom_range(0, 4095));
            apply(x);
            check_all($sformatf("rnd%0d", n), m_pc, m_mis, m_ras.size(),
                      (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter stage. It holds the architectural PC register and computes next-PC for the following cases: sequential, conditional branch, JAL, JALR and trap redirect. It also flags misaligned control-flow targets and maintains a small return-address stack (RAS) for call/return prediction. It sits at the head of the fetch path, and its PC output drives instruction memory.

Parameters:
XLEN, 64, datapath width of PC, immediate and rs1 operand
IMM_SHIFT, 1, left shift applied to immd for branch/JAL targets
RESET_VECTOR, 64'h0, PC value loaded on reset (truncated to XLEN)
TRAP_VECTOR, 64'h100, PC loaded on misaligned target (truncated to XLEN)
RAS_DEPTH, 4, return-address stack entries, power of two, >=2

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold all state (PC, RAS, misalign) this cycle
branch  input  1  conditional branch taken
jal  input  1  JAL instruction
jalr  input  1  JALR instruction
call  input  1  push return address pc+4 onto RAS (qualifies jal/jalr)
ret  input  1  pop RAS
immd  input  XLEN  sign-extended immediate
rs1_val  input  XLEN  JALR base register value
pc  output  XLEN  current PC (registered)
pc_plus4  output  XLEN  pc + 4 (combinational)
misalign  output  1  registered one-cycle pulse: last redirect target was misaligned
ras_top  output  XLEN  top RAS entry (combinational from state)
ras_valid  output  1  ras_count != 0
ras_count  output  clog2(RAS_DEPTH)+1  occupied entries, saturating at RAS_DEPTH

Behaviour:
- Reset (sync, highest priority): pc=RESET_VECTOR, misalign=0, ras_count=0, RAS pointer=0. RAS entry contents are don't-care, but ras_top must not be X-propagated into control logic.
- Stall (when not in reset): pc, RAS and misalign hold their values. Control inputs are ignored.
- Target selection, in priority order:
  - jalr: (rs1_val + immd) & ~1
  - else branch or jal: pc + (immd << IMM_SHIFT)
  - else: pc + 4
- All arithmetic is modulo 2^XLEN. Wrap-around is silent.
- Misalignment: a redirect (jalr/branch/jal) whose target[1:0] != 2'b00 loads pc=TRAP_VECTOR and sets misalign=1 for exactly one cycle. The sequential path never flags misalignment.
- misalign clears on the next non-stalled cycle.
- One-cycle latency: the selected target appears on pc the cycle after the inputs are sampled.
- RAS is a circular buffer with a write pointer wp. Updates happen only when the stage is not stalled and not in reset.
  - push only (call && !ret): entry[wp]=pc+4, wp++, count=min(count+1, RAS_DEPTH). On overflow the oldest entry is silently overwritten.
  - pop only (ret && !call): if count>0 then wp--, count--. If count==0 the pop is a no-op.
  - call && ret together: entry[wp-1]=pc+4 (replace top), wp and count unchanged. If count==0, treat as push.
- ras_top = entry[wp-1]. It is valid only when ras_valid=1.
- A call on a misaligned redirect still pushes pc+4.
- Reset asserted mid-operation overrides all inputs in that cycle.

Test Plan:
1. Reset, then 3 idle cycles -> pc = 0, 4, 8, 12. misalign=0, ras_count=0.
2. pc=0x40, branch=1, immd=0x10 -> pc=0x60 next cycle. Same cycle with jalr=1, rs1_val=0x201, immd=0 -> jalr wins, pc=0x200.
3. pc=0x40, jal=1, immd=0x1 (target 0x42) -> pc=0x100, misalign=1 for one cycle, then pc=0x104, misalign=0.
4. Stall held 3 cycles with branch=1 and call=1 -> pc, ras_count and misalign unchanged. Release stall -> normal advance.
5. Five calls at pc=0x0,0x10,0x20,0x30,0x40, RAS_DEPTH=4 -> ras_count=4, ras_top=0x44. Four rets -> tops 0x34, 0x24, 0x14, then ras_valid=0. A fifth ret is a no-op with count stays 0.
6. count=2, top=0x14; call && ret at pc=0x80 -> top=0x84, count=2. Reset the next cycle -> pc=RESET_VECTOR, ras_count=0.
